// File: rtl/link_symbols_pkg.sv
// Link symbol definitions shared by the transmit framer and the receive-side splitter.
// Holds the K-code byte values and the framer state encoding.
package link_symbols_pkg;

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;
   localparam logic [7:0] K_SKP = 8'h1C;
   localparam logic [7:0] K_IDL = 8'h7C;
   localparam logic [7:0] K_FTS = 8'h3C;
   localparam logic [7:0] K_COM = 8'hBC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_PAYLOAD,
      ST_END,
      ST_DRAIN,
      ST_SKP_COM,
      ST_SKP_SYM
   } framer_state_e;

   function automatic logic [7:0] start_symbol(input logic is_dllp);
      return is_dllp ? K_SDP : K_STP;
   endfunction

endpackage

// File: rtl/skp_scheduler.sv
// Free-running interval counter that raises a sticky SKP request at every wrap.
// A wrap coinciding with clear keeps the request set.
module skp_scheduler #(
   parameter int SKP_INTERVAL = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic pending
);

   localparam int CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             wrap;

   always_comb begin
      wrap      = (cnt_q == CNT_W'(SKP_INTERVAL - 1));
      cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
      pending_d = wrap | (pending_q & ~clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/tx_framer.sv
// Transmit framer: wraps handshaked packet bytes in STP/SDP..END, fills gaps with IDL,
// aborts underflowed packets with EDB and inserts COM+SKP ordered sets between packets.
module tx_framer
   import link_symbols_pkg::*;
#(
   parameter int SKP_INTERVAL = 64,
   parameter int SKP_LEN      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   input  logic       last_in,
   input  logic       pkt_type_in,
   output logic       ready_out,
   output logic [7:0] data_out,
   output logic       k_out,
   output logic       valid_out
);

   framer_state_e state_q, state_d;
   logic          type_q, type_d;
   logic [2:0]    skp_cnt_q, skp_cnt_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          k_out_q, k_out_d;
   logic          valid_out_q;
   logic          skp_pending;
   logic          skp_clear;

   skp_scheduler #(
      .SKP_INTERVAL(SKP_INTERVAL)
   ) u_skp_scheduler (
      .clk    (clk),
      .reset  (reset),
      .clear  (skp_clear),
      .pending(skp_pending)
   );

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      skp_cnt_d  = skp_cnt_q;
      data_out_d = K_IDL;
      k_out_d    = 1'b1;
      ready_out  = 1'b0;
      skp_clear  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_END: begin
            data_out_d = (state_q == ST_END) ? K_END : K_IDL;
            // A pending ordered set takes priority over a waiting packet.
            if (skp_pending) begin
               state_d = ST_SKP_COM;
            end else if (valid_in) begin
               state_d = ST_START;
               type_d  = pkt_type_in;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            data_out_d = start_symbol(type_q);
            state_d    = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            ready_out = 1'b1;
            if (valid_in) begin
               data_out_d = data_in;
               k_out_d    = 1'b0;
               if (last_in) state_d = ST_END;
            end else begin
               data_out_d = K_EDB;
               state_d    = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            ready_out = 1'b1;
            if (valid_in && last_in) state_d = ST_IDLE;
         end
         ST_SKP_COM: begin
            data_out_d = K_COM;
            skp_clear  = 1'b1;
            skp_cnt_d  = '0;
            state_d    = ST_SKP_SYM;
         end
         ST_SKP_SYM: begin
            data_out_d = K_SKP;
            if (skp_cnt_q == 3'(SKP_LEN - 1)) begin
               state_d = ST_IDLE;
            end else begin
               skp_cnt_d = skp_cnt_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         type_q      <= 1'b0;
         skp_cnt_q   <= '0;
         data_out_q  <= 8'h00;
         k_out_q     <= 1'b0;
         valid_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         skp_cnt_q   <= skp_cnt_d;
         data_out_q  <= data_out_d;
         k_out_q     <= k_out_d;
         valid_out_q <= 1'b1;
      end
   end

   assign data_out  = data_out_q;
   assign k_out     = k_out_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer: randomized packet source checked against a cycle-level reference
// of the framing rules, plus fixed symbol sequences for the key scenarios.
module tb_tx_framer;

   localparam int SKP_INTERVAL = 16;
   localparam int SKP_LEN      = 3;

   localparam int P_IDLE    = 0;
   localparam int P_START   = 1;
   localparam int P_PAYLOAD = 2;
   localparam int P_END     = 3;
   localparam int P_DRAIN   = 4;
   localparam int P_SKP_COM = 5;
   localparam int P_SKP_SYM = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       last_in = 1'b0;
   logic       pkt_type_in = 1'b0;
   logic       ready_out;
   logic [7:0] data_out;
   logic       k_out;
   logic       valid_out;

   tx_framer #(
      .SKP_INTERVAL(SKP_INTERVAL),
      .SKP_LEN     (SKP_LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .last_in    (last_in),
      .pkt_type_in(pkt_type_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .k_out      (k_out),
      .valid_out  (valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       typ;
      int         gap;
   } beat_t;

   beat_t      src_q[$];
   logic [8:0] obs[$];
   logic [8:0] seq_w[$];
   logic [7:0] pb[$];
   int         n_chk = 0;
   int         n_fail = 0;

   int         m_phase;
   int         m_cyc;
   int         m_skp;
   bit         m_pend;
   bit         m_type;
   logic [7:0] exp_d;
   bit         exp_k;
   bit         exp_v;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic bit m_ready();
      return (m_phase == P_PAYLOAD) || (m_phase == P_DRAIN);
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_cyc   = 0;
      m_skp   = 0;
      m_pend  = 1'b0;
      m_type  = 1'b0;
      exp_d   = 8'h00;
      exp_k   = 1'b0;
      exp_v   = 1'b0;
   endtask

   // Reference: symbol chosen by the current phase, then the phase advances.
   task automatic model_step(input bit v, input logic [7:0] d, input bit l, input bit t);
      int         prev = m_phase;
      logic [7:0] s = 8'h7C;
      bit         k = 1'b1;
      case (m_phase)
         P_IDLE, P_END: begin
            s = (m_phase == P_END) ? 8'hFD : 8'h7C;
            if (m_pend) m_phase = P_SKP_COM;
            else if (v) begin
               m_phase = P_START;
               m_type  = t;
            end else m_phase = P_IDLE;
         end
         P_START: begin
            s = m_type ? 8'h5C : 8'hFB;
            m_phase = P_PAYLOAD;
         end
         P_PAYLOAD: begin
            if (v) begin
               s = d;
               k = 1'b0;
               if (l) m_phase = P_END;
            end else begin
               s = 8'hFE;
               m_phase = P_DRAIN;
            end
         end
         P_DRAIN: if (v && l) m_phase = P_IDLE;
         P_SKP_COM: begin
            s = 8'hBC;
            m_skp = 0;
            m_phase = P_SKP_SYM;
         end
         default: begin
            s = 8'h1C;
            m_skp++;
            if (m_skp == SKP_LEN) m_phase = P_IDLE;
         end
      endcase
      // A request appears every SKP_INTERVAL edges after reset; a new request beats a clear.
      m_cyc++;
      if (m_cyc % SKP_INTERVAL == 0) m_pend = 1'b1;
      else if (prev == P_SKP_COM) m_pend = 1'b0;
      exp_d = s;
      exp_k = k;
      exp_v = 1'b1;
   endtask

   task automatic cycle();
      bit acc;
      if (src_q.size() > 0 && src_q[0].gap > 0) begin
         valid_in = 1'b0;
         data_in  = 8'($urandom);
         last_in  = 1'($urandom);
         src_q[0].gap = src_q[0].gap - 1;
      end else if (src_q.size() > 0) begin
         valid_in    = 1'b1;
         data_in     = src_q[0].data;
         last_in     = src_q[0].last;
         pkt_type_in = src_q[0].typ;
      end else begin
         valid_in    = 1'b0;
         data_in     = 8'($urandom);
         last_in     = 1'($urandom);
         pkt_type_in = 1'($urandom);
      end
      acc = valid_in && m_ready();
      model_step(valid_in, data_in, last_in, pkt_type_in);
      @(posedge clk);
      #1;
      chk("data_out", data_out, exp_d);
      chk("k_out", k_out, exp_k);
      chk("valid_out", valid_out, exp_v);
      chk("ready_out", ready_out, m_ready());
      obs.push_back({k_out, data_out});
      if (acc) void'(src_q.pop_front());
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain_src(input string tag, input int max_cyc);
      int n = 0;
      while (src_q.size() > 0 && n < max_cyc) begin
         cycle();
         n++;
      end
      chk({tag, "_done"}, src_q.size(), 0);
   endtask

   task automatic add_pkt(input bit typ, input logic [7:0] b[$], input int gap_idx,
                          input int gap_len);
      beat_t e;
      for (int i = 0; i < b.size(); i++) begin
         e.data = b[i];
         e.last = (i == b.size() - 1);
         e.typ  = typ;
         e.gap  = (i == gap_idx) ? gap_len : 0;
         src_q.push_back(e);
      end
   endtask

   task automatic seq_check(input string tag, input int from, input logic [8:0] w[$]);
      int at = -1;
      for (int i = from; i < obs.size(); i++) begin
         if (obs[i] == w[0]) begin
            at = i;
            break;
         end
      end
      chk({tag, "_found"}, at >= 0, 1);
      if (at >= 0) begin
         for (int j = 0; j < w.size(); j++) begin
            chk(tag, (at + j < obs.size()) ? obs[at + j] : 9'h000, w[j]);
         end
      end
   endtask

   initial begin
      int mark;
      int at_fb;
      int at_fd;
      int ncom;

      model_reset();
      #3;
      chk("rst_data", data_out, 8'h00);
      chk("rst_k", k_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_ready", ready_out, 0);
      #17;
      reset = 1'b0;

      run(1);
      chk("first_edge", {valid_out, k_out, data_out}, 10'h37C);
      run(19);

      // TLP followed back-to-back by a DLLP
      mark = obs.size();
      pb = '{8'h11, 8'h22, 8'h33, 8'h44};
      add_pkt(1'b0, pb, -1, 0);
      pb = '{8'hAA, 8'hBB};
      add_pkt(1'b1, pb, -1, 0);
      drain_src("b2b", 200);
      run(4);
      seq_w = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD,
                9'h15C, 9'h0AA, 9'h0BB, 9'h1FD};
      seq_check("b2b", mark, seq_w);

      // Underflow after two bytes; remainder discarded in DRAIN
      mark = obs.size();
      pb = '{8'h5A, 8'hC3, 8'h77, 8'h99};
      add_pkt(1'b0, pb, 2, 2);
      drain_src("underflow", 200);
      run(4);
      seq_w = '{9'h1FB, 9'h05A, 9'h0C3, 9'h1FE, 9'h17C, 9'h17C};
      seq_check("underflow", mark, seq_w);

      // 20-byte packet spanning an interval wrap, K-valued payload bytes
      mark = obs.size();
      pb.delete();
      pb.push_back(8'hFB);
      pb.push_back(8'hBC);
      for (int i = 2; i < 20; i++) pb.push_back(8'($urandom));
      add_pkt(1'b0, pb, -1, 0);
      pb = '{8'h42};
      add_pkt(1'b1, pb, -1, 0);
      drain_src("long", 300);
      run(8);
      at_fb = -1;
      at_fd = -1;
      ncom  = 0;
      for (int i = mark; i < obs.size(); i++) begin
         if (obs[i] == 9'h1FB) begin
            at_fb = i;
            break;
         end
      end
      if (at_fb >= 0) begin
         for (int i = at_fb + 1; i < obs.size(); i++) begin
            if (obs[i] == 9'h1FD) begin
               at_fd = i;
               break;
            end
            if (obs[i] == 9'h1BC) ncom++;
         end
      end
      chk("long_found", (at_fb >= 0) && (at_fd >= 0), 1);
      chk("long_len", at_fd - at_fb, 21);
      chk("no_com_in_pkt", ncom, 0);
      seq_w = '{9'h1FB, 9'h0FB, 9'h0BC};
      seq_check("long_head", mark, seq_w);
      seq_w = '{9'h1FD, 9'h1BC, 9'h11C, 9'h11C, 9'h11C};
      seq_check("long_tail", (at_fd >= 0) ? at_fd : mark, seq_w);

      // Randomized packets with idle gaps and occasional underflow
      for (int p = 0; p < 14; p++) begin
         int len = $urandom_range(1, 12);
         pb.delete();
         for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
         if ($urandom_range(0, 3) == 0)
            add_pkt(1'($urandom), pb, $urandom_range(0, len - 1), $urandom_range(1, 3));
         else
            add_pkt(1'($urandom), pb, 0, $urandom_range(0, 4));
      end
      drain_src("random", 3000);
      run(6);

      // Asynchronous reset in the middle of a payload
      pb = '{8'h01, 8'h02, 8'hFB, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      add_pkt(1'b0, pb, -1, 0);
      for (int i = 0; i < 100 && src_q.size() > 5; i++) cycle();
      chk("fb_payload_k0", {k_out, data_out}, 9'h0FB);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_data", data_out, 8'h00);
      chk("async_rst_k", k_out, 0);
      chk("async_rst_valid", valid_out, 0);
      chk("async_rst_ready", ready_out, 0);
      @(posedge clk);
      #1;
      chk("held_rst_out", {valid_out, k_out, data_out}, 10'h000);
      @(negedge clk);
      reset = 1'b0;
      src_q.delete();
      valid_in = 1'b0;
      model_reset();
      run(1);
      chk("post_rst_first", {valid_out, k_out, data_out}, 10'h37C);
      run(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
